// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched
//
// Purpose:
//   Sequences the 10-bit test-pattern frame generator (HEAD, PRBS_LENGTH PRBS
//   words, TAIL). On a start command it pulses the generator's send_enable so
//   that a programmed number of frames goes out, either back-to-back or with a
//   programmed number of idle words between frames. The block tracks frame
//   boundaries itself (the generator gives no feedback) and reports busy,
//   done, a frame-start marker and the count of completed frames. An abort
//   request stops the run cleanly at the next frame boundary.
//
// Ports:
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset (shared with generator)
//   start        in   1      single-cycle run request, honoured only when idle
//   abort        in   1      single-cycle stop request, honoured at a frame boundary
//   frame_count  in   CNT_W  frames per run, 0 = run until aborted (latched on start)
//   gap_cycles   in   GAP_W  idle words between frames (latched on start)
//   send_enable  out  1      to generator send_enable (combinational)
//   frame_start  out  1      high while the generator is outputting HEAD
//   busy         out  1      a run is in progress
//   done         out  1      one-cycle pulse in the first idle cycle after a run
//   frames_sent  out  CNT_W  completed frames in the current/last run
// -----------------------------------------------------------------------------
module frame_sched #(
    parameter int PRBS_LENGTH = 8,
    parameter int CNT_W       = 16,
    parameter int GAP_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] frame_count,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             send_enable,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    // Frame length in words: HEAD + PRBS words + TAIL.
    localparam int FL    = PRBS_LENGTH + 2;
    localparam int POS_W = (FL > 1) ? $clog2(FL) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [POS_W-1:0]   pos_q,        pos_d;
    logic [GAP_W-1:0]   gcnt_q,       gcnt_d;
    logic [CNT_W-1:0]   cnt_cfg_q,    cnt_cfg_d;
    logic [GAP_W-1:0]   gap_cfg_q,    gap_cfg_d;
    logic [CNT_W-1:0]   fsent_q,      fsent_d;
    logic               abort_pend_q, abort_pend_d;
    logic               done_q,       done_d;

    logic               tail;
    logic               below_count;
    logic               more;

    // Compare one bit wider so frames_sent+1 cannot wrap to a small value
    // and falsely allow another frame when frames_sent is all ones.
    assign below_count = ({1'b0, fsent_q} + {{CNT_W{1'b0}}, 1'b1}) < {1'b0, cnt_cfg_q};
    assign tail        = (pos_q == POS_LAST);
    assign more        = ((cnt_cfg_q == '0) || below_count) && !abort_pend_q && !abort;

    // -------------------------------------------------------------------------
    // Next-state and send_enable decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        gcnt_d       = gcnt_q;
        cnt_cfg_d    = cnt_cfg_q;
        gap_cfg_d    = gap_cfg_q;
        fsent_d      = fsent_q;
        abort_pend_d = abort_pend_q | abort;
        done_d       = 1'b0;
        send_enable  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An abort arriving while idle must not poison the next run.
                abort_pend_d = 1'b0;
                if (start && !abort) begin
                    state_d   = S_LAUNCH;
                    cnt_cfg_d = frame_count;
                    gap_cfg_d = gap_cycles;
                    fsent_d   = '0;
                end
            end

            S_LAUNCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    send_enable = 1'b1;
                    state_d     = S_FRAME;
                    pos_d       = '0;
                end
            end

            S_FRAME: begin
                if (tail) begin
                    fsent_d = fsent_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (more) begin
                        if (gap_cfg_q == '0) begin
                            // Request the next frame now so its HEAD follows
                            // this TAIL with no idle word in between.
                            send_enable = 1'b1;
                            pos_d       = '0;
                        end else begin
                            state_d = S_GAP;
                            gcnt_d  = gap_cfg_q;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pos_d = pos_q + {{(POS_W-1){1'b0}}, 1'b1};
                end
            end

            S_GAP: begin
                if (abort || abort_pend_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gcnt_q == {{(GAP_W-1){1'b0}}, 1'b1}) begin
                    // The generator answers one cycle later, so requesting in
                    // the last gap cycle yields exactly gap_cycles idle words.
                    send_enable = 1'b1;
                    state_d     = S_FRAME;
                    pos_d       = '0;
                end else begin
                    gcnt_d = gcnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            gcnt_q       <= '0;
            cnt_cfg_q    <= '0;
            gap_cfg_q    <= '0;
            fsent_q      <= '0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            gcnt_q       <= gcnt_d;
            cnt_cfg_q    <= cnt_cfg_d;
            gap_cfg_q    <= gap_cfg_d;
            fsent_q      <= fsent_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
        end
    end

    assign frame_start = (state_q == S_FRAME) && (pos_q == '0);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign frames_sent = fsent_q;

endmodule

// File: tb/tb_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_frame_sched
//
// Self-checking bench for frame_sched (PRBS_LENGTH=8, FL=10). Each run is
// described by frame count, gap, abort cycle and reset cycle; a schedule model
// works out frame HEAD/TAIL cycles from the frame length and gap and turns
// them into expected per-cycle outputs, which are compared every cycle.
// Cycle 0 of a run is the cycle in which start is driven.
// -----------------------------------------------------------------------------
module tb_frame_sched;

    localparam int PL   = 8;
    localparam int FL   = PL + 2;
    localparam int CW   = 16;
    localparam int GW   = 8;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] frame_count;
    logic [GW-1:0] gap_cycles;
    logic          send_enable;
    logic          frame_start;
    logic          busy;
    logic          done;
    logic [CW-1:0] frames_sent;

    int n_tests = 0;
    int n_fail  = 0;
    int prev_fsent = 0;

    bit exp_se   [MAXC];
    bit exp_fs   [MAXC];
    bit exp_busy [MAXC];
    bit exp_done [MAXC];
    int exp_fsent[MAXC];

    frame_sched #(
        .PRBS_LENGTH(PL),
        .CNT_W      (CW),
        .GAP_W      (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .frame_count(frame_count),
        .gap_cycles (gap_cycles),
        .send_enable(send_enable),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Build the expected waveform for one run from the frame schedule.
    //   C: frame count (0 = continuous), G: gap words,
    //   A: abort cycle (-1 none), R: reset cycle (0 none). Returns run length.
    task automatic build_model(input int C, input int G, input int A, input int R, output int ncyc);
        int tails[$];
        int done_c;
        int h;
        bit ended;
        for (int c = 0; c < MAXC; c++) begin
            exp_se[c] = 0; exp_fs[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_fsent[c] = 0;
        end
        done_c = 0;
        if (A == 1) begin
            done_c = 2;
        end else begin
            exp_se[1] = 1;
            h = 2;
            ended = 0;
            for (int k = 0; k < 64 && !ended; k++) begin
                int t;
                int nh;
                bit more;
                t = h + FL - 1;
                exp_fs[h] = 1;
                tails.push_back(t);
                more = ((C == 0) || (k + 1 < C)) && !(A >= 1 && A <= t);
                nh = t + 1 + G;
                if (!more) begin
                    done_c = t + 1;
                    ended = 1;
                end else if (G > 0 && A >= t + 1 && A <= nh - 1) begin
                    done_c = A + 1;
                    ended = 1;
                end else begin
                    exp_se[nh - 1] = 1;
                    h = nh;
                end
            end
        end
        for (int c = 1; c < done_c; c++) exp_busy[c] = 1;
        exp_done[done_c] = 1;
        for (int c = 0; c < MAXC; c++) begin
            if (c == 0) begin
                exp_fsent[c] = prev_fsent;
            end else begin
                int n;
                n = 0;
                foreach (tails[i]) if (tails[i] < c) n++;
                exp_fsent[c] = n;
            end
        end
        if (R > 0) begin
            for (int c = R + 1; c < MAXC; c++) begin
                exp_se[c] = 0; exp_fs[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_fsent[c] = 0;
            end
            ncyc = R + 4;
        end else begin
            ncyc = done_c + 3;
        end
    endtask

    // Called just after a rising edge. extra_start re-pulses start at cycle 5.
    task automatic run_case(input string name, input int C, input int G, input int A,
                            input int R, input bit extra_start);
        int ncyc;
        build_model(C, G, A, R, ncyc);
        $display("[TB] run %s: count=%0d gap=%0d abort=%0d rst=%0d", name, C, G, A, R);
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (extra_start && c == 5);
            abort = (c == A);
            rst   = (R > 0) && (c == R);
            // Outside the start cycle the config inputs carry junk, which must
            // be ignored because the config is latched on the accepted start.
            frame_count = (c == 0) ? CW'(C) : CW'($urandom_range(0, 7));
            gap_cycles  = (c == 0) ? GW'(G) : GW'($urandom_range(0, 7));
            @(negedge clk);
            chk({name, ".send_enable"}, c, 32'(send_enable), 32'(exp_se[c]));
            chk({name, ".frame_start"}, c, 32'(frame_start), 32'(exp_fs[c]));
            chk({name, ".busy"},        c, 32'(busy),        32'(exp_busy[c]));
            chk({name, ".done"},        c, 32'(done),        32'(exp_done[c]));
            chk({name, ".frames_sent"}, c, 32'(frames_sent), 32'(exp_fsent[c]));
            @(posedge clk);
            #1;
        end
        start = 0;
        abort = 0;
        rst   = 0;
        prev_fsent = exp_fsent[ncyc - 1];
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; frame_count = '0; gap_cycles = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.send_enable", 0, 32'(send_enable), 32'd0);
        chk("reset.frame_start", 0, 32'(frame_start), 32'd0);
        chk("reset.busy",        0, 32'(busy),        32'd0);
        chk("reset.done",        0, 32'(done),        32'd0);
        chk("reset.frames_sent", 0, 32'(frames_sent), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;

        // Directed scenarios.
        run_case("b2b3",      3, 0, -1, 0, 0);
        run_case("gap3",      2, 3, -1, 0, 0);
        run_case("contabort", 0, 0, 15, 0, 0);
        run_case("gapabort",  5, 4, 13, 0, 0);
        run_case("launchab",  2, 1,  1, 0, 0);
        run_case("busystart", 3, 0, -1, 0, 1);

        // start together with abort while idle must be ignored.
        start = 1; abort = 1; frame_count = CW'(2); gap_cycles = '0;
        @(posedge clk);
        #1;
        start = 0; abort = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("startabort.busy",        c, 32'(busy),        32'd0);
            chk("startabort.send_enable", c, 32'(send_enable), 32'd0);
            chk("startabort.frames_sent", c, 32'(frames_sent), 32'(prev_fsent));
            @(posedge clk);
            #1;
        end

        // Reset mid-frame, then a normal run afterwards.
        run_case("midrst",   3, 0, -1, 7, 0);
        run_case("afterrst", 1, 2, -1, 0, 0);

        // Randomized runs.
        for (int i = 0; i < 10; i++) begin
            int C;
            int G;
            int A;
            C = $urandom_range(0, 4);
            G = $urandom_range(0, 5);
            if (C == 0)
                A = $urandom_range(1, 50);
            else if ($urandom_range(0, 1) == 1)
                A = $urandom_range(1, 2 + C * (FL + G));
            else
                A = -1;
            run_case($sformatf("rand%0d", i), C, G, A, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
